// File: rtl/online_digit_history.sv
// online_digit_history
//   History buffer for online (MSD-first) signed-digit operands. Each word holds
//   DIGITS_PER_WORD slots; each slot holds one {plus,minus} digit per channel plus
//   a valid bit. Writes are a single-cycle read-modify-write of one slot; reads are
//   registered with latency 1. A clear sweep zeroes one word per cycle after reset
//   or on clr_req.
//
//   Optional feature macro: DHB_FWD_EN
//     defined   : a read of the word being written in the same cycle returns the
//                 merged (post-write) word.
//     undefined : such a read returns the pre-write contents; the write still commits.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          asynchronous active-high reset; restarts the clear sweep
//   clr_req      start a clear sweep (accepted only when idle); also clears err
//   busy         clear sweep in progress
//   wr_en        write one digit set into wr_addr / wr_slot
//   wr_addr      word address (computation cycle)
//   wr_slot      slot within the word
//   wr_digit     {ch[N-1].plus, ch[N-1].minus, ..., ch0.plus, ch0.minus}
//   rd_en        read request for rd_addr
//   rd_addr      read word address
//   rd_valid     rd_* data valid, one cycle after rd_en
//   rd_plus      ch c, slot k at bit c*DPW + (DPW-1-k)
//   rd_minus     same mapping as rd_plus
//   rd_slot_vld  bit k set when slot k has been written since the last clear
//   rd_full      every slot of the word is valid
//   err          sticky: [0] illegal digit 11 written, [1] write dropped

module online_digit_history #(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned DIGITS_PER_WORD = 4,
  parameter int unsigned ADDR_W          = 7,
  parameter int unsigned DEPTH           = 128,
  parameter int unsigned SLOT_W          = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr_req,
  output logic                                 busy,
  input  logic                                 wr_en,
  input  logic [ADDR_W-1:0]                    wr_addr,
  input  logic [SLOT_W-1:0]                    wr_slot,
  input  logic [2*NUM_CH-1:0]                  wr_digit,
  input  logic                                 rd_en,
  input  logic [ADDR_W-1:0]                    rd_addr,
  output logic                                 rd_valid,
  output logic [NUM_CH*DIGITS_PER_WORD-1:0]    rd_plus,
  output logic [NUM_CH*DIGITS_PER_WORD-1:0]    rd_minus,
  output logic [DIGITS_PER_WORD-1:0]           rd_slot_vld,
  output logic                                 rd_full,
  output logic [1:0]                           err
);

  localparam int unsigned DPW    = DIGITS_PER_WORD;
  localparam int unsigned WORD_W = NUM_CH * DPW;

  // One extra bit so DEPTH == 2**ADDR_W is representable as a limit.
  localparam logic [ADDR_W:0]   DEPTH_LIM = DEPTH[ADDR_W:0];
  localparam logic [SLOT_W:0]   DPW_LIM   = DPW[SLOT_W:0];
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              clr_accept;

  // Storage arrays; no reset, the clear sweep initialises them.
  logic [WORD_W-1:0] mem_plus  [DEPTH];
  logic [WORD_W-1:0] mem_minus [DEPTH];
  logic [DPW-1:0]    mem_vld   [DEPTH];

  logic              wr_addr_ok, wr_slot_ok, rd_addr_ok;
  logic              wr_ok, wr_drop;
  logic [ADDR_W-1:0] wr_idx, rd_idx;

  logic [NUM_CH-1:0] dig_p, dig_m, dig_bad;
  logic [WORD_W-1:0] cur_plus, cur_minus, mrg_plus, mrg_minus;
  logic [DPW-1:0]    cur_vld, mrg_vld;

  logic [WORD_W-1:0] rdw_plus, rdw_minus;
  logic [DPW-1:0]    rdw_vld;
  logic [1:0]        err_d;

  // ---------------------------------------------------------------------------
  // Clear-sweep FSM
  // ---------------------------------------------------------------------------
  assign busy = (state_q == StClear);

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    clr_accept = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d    = StClear;
          sweep_d    = '0;
          clr_accept = 1'b1;
        end
      end
      StClear: begin
        // clr_req is ignored while sweeping.
        if (sweep_q == LAST_ADDR) begin
          state_d = StIdle;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StClear;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Write qualification and merge
  // ---------------------------------------------------------------------------
  assign wr_addr_ok = ({1'b0, wr_addr} < DEPTH_LIM);
  assign wr_slot_ok = ({1'b0, wr_slot} < DPW_LIM);
  assign rd_addr_ok = ({1'b0, rd_addr} < DEPTH_LIM);

  assign wr_ok   = wr_en && !busy && wr_addr_ok && wr_slot_ok;
  assign wr_drop = wr_en && !wr_ok;

  // Out-of-range addresses are steered to word 0 so the array is never
  // indexed past its end; the result is masked or unused in that case.
  assign wr_idx = wr_addr_ok ? wr_addr : '0;
  assign rd_idx = rd_addr_ok ? rd_addr : '0;

  assign cur_plus  = mem_plus[wr_idx];
  assign cur_minus = mem_minus[wr_idx];
  assign cur_vld   = mem_vld[wr_idx];

  always_comb begin
    dig_p   = '0;
    dig_m   = '0;
    dig_bad = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      dig_p[c]   = wr_digit[2*c+1];
      dig_m[c]   = wr_digit[2*c];
      dig_bad[c] = wr_digit[2*c+1] & wr_digit[2*c];
    end
  end

  // Replace only the addressed slot; an illegal 11 digit is stored as 00.
  always_comb begin
    mrg_plus  = cur_plus;
    mrg_minus = cur_minus;
    mrg_vld   = cur_vld;
    for (int k = 0; k < DPW; k++) begin
      if (wr_slot == SLOT_W'(k)) begin
        mrg_vld[k] = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
          mrg_plus[c*DPW + DPW-1-k]  = dig_p[c] & ~dig_bad[c];
          mrg_minus[c*DPW + DPW-1-k] = dig_m[c] & ~dig_bad[c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_plus[sweep_q]  <= '0;
      mem_minus[sweep_q] <= '0;
      mem_vld[sweep_q]   <= '0;
    end else if (wr_ok) begin
      mem_plus[wr_idx]  <= mrg_plus;
      mem_minus[wr_idx] <= mrg_minus;
      mem_vld[wr_idx]   <= mrg_vld;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags; a set event in the clr_req cycle wins over the clear.
  // ---------------------------------------------------------------------------
  always_comb begin
    err_d = err;
    if (clr_accept) begin
      err_d = '0;
    end
    if (wr_ok && (|dig_bad)) begin
      err_d[0] = 1'b1;
    end
    if (wr_drop) begin
      err_d[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= '0;
    end else begin
      err <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read port
  // ---------------------------------------------------------------------------
  always_comb begin
    rdw_plus  = '0;
    rdw_minus = '0;
    rdw_vld   = '0;
    if (rd_addr_ok) begin
      rdw_plus  = mem_plus[rd_idx];
      rdw_minus = mem_minus[rd_idx];
      rdw_vld   = mem_vld[rd_idx];
    end
`ifdef DHB_FWD_EN
    // wr_ok implies wr_addr is in range, so a match implies rd_addr is too.
    if (wr_ok && (rd_addr == wr_addr)) begin
      rdw_plus  = mrg_plus;
      rdw_minus = mrg_minus;
      rdw_vld   = mrg_vld;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid    <= 1'b0;
      rd_plus     <= '0;
      rd_minus    <= '0;
      rd_slot_vld <= '0;
      rd_full     <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      // Data holds between reads.
      if (rd_en) begin
        rd_plus     <= rdw_plus;
        rd_minus    <= rdw_minus;
        rd_slot_vld <= rdw_vld;
        rd_full     <= &rdw_vld;
      end
    end
  end

endmodule
